embedded_system_onchip_memory_dp: RTL and testbench

//  Parametrised dual-port on-chip RAM with two Avalon-MM slaves (s1, s2) for the

---
 rtl/embedded_system_onchip_memory_dp.sv | 155 +++++++++++++++
 tb/tb_embedded_system_onchip_memory_dp.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/embedded_system_onchip_memory_dp.sv
// Dual-port on-chip RAM with two Avalon-MM slaves, byte enables and optional zero-fill after reset.
// Latency: READ_LATENCY (1 or 2) enabled cycles from accepted read to readdatavalid; writes land at the accepting edge.
// Backpressure: waitrequest is high on both ports while the array is being cleared; clken/reset_req freeze the whole block.
module embedded_system_onchip_memory_dp #(
  parameter int DATA_WIDTH     = 32,
  parameter int DEPTH          = 32000,
  parameter int ADDR_WIDTH     = 15,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 0,
  // Contents preload is left to the implementation flow that consumes this name.
  parameter     INIT_FILE      = "embedded_system_onchip_memory_dp.hex"
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    reset_req,
  input  logic                    clken,
  input  logic [ADDR_WIDTH-1:0]   s1_address,
  input  logic                    s1_chipselect,
  input  logic                    s1_read,
  input  logic                    s1_write,
  input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
  input  logic [DATA_WIDTH-1:0]   s1_writedata,
  output logic [DATA_WIDTH-1:0]   s1_readdata,
  output logic                    s1_readdatavalid,
  output logic                    s1_waitrequest,
  input  logic [ADDR_WIDTH-1:0]   s2_address,
  input  logic                    s2_chipselect,
  input  logic                    s2_read,
  input  logic                    s2_write,
  input  logic [DATA_WIDTH/8-1:0] s2_byteenable,
  input  logic [DATA_WIDTH-1:0]   s2_writedata,
  output logic [DATA_WIDTH-1:0]   s2_readdata,
  output logic                    s2_readdatavalid,
  output logic                    s2_waitrequest,
  output logic                    clear_done
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [ADDR_WIDTH:0] DEPTH_A = (ADDR_WIDTH + 1)'(DEPTH);
  // The clear counter runs one step past the last word so READY arrives the cycle after it is written.
  localparam logic [CW-1:0]       CLR_END = CW'(DEPTH);

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  state_t                  state, state_nxt;
  logic [CW-1:0]           clr_addr, clr_nxt;
  logic                    en, ready, clr_wr;

  logic [1:0]              cs_i, rd_i, wr_i;
  logic [ADDR_WIDTH-1:0]   addr_i [2];
  logic [NB-1:0]           be_i   [2];
  logic [DATA_WIDTH-1:0]   wd_i   [2];

  logic [1:0]              rd_acc, wr_acc, in_rng;
  logic [DATA_WIDTH-1:0]   rd_word [2];

  logic [1:0]              p1_vld, out_vld;
  logic [DATA_WIDTH-1:0]   p1_dat  [2];
  logic [DATA_WIDTH-1:0]   out_dat [2];

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  assign en     = clken & ~reset_req;
  assign ready  = (state == ST_READY);
  assign clr_wr = (state == ST_CLEAR) & en & ~reset & (clr_addr != CLR_END);

  // Port 1 is index 0, port 2 is index 1.
  assign cs_i      = {s2_chipselect, s1_chipselect};
  assign rd_i      = {s2_read, s1_read};
  assign wr_i      = {s2_write, s1_write};
  assign addr_i[0] = s1_address;
  assign addr_i[1] = s2_address;
  assign be_i[0]   = s1_byteenable;
  assign be_i[1]   = s2_byteenable;
  assign wd_i[0]   = s1_writedata;
  assign wd_i[1]   = s2_writedata;

  // FSM state and clear counter; a reset anywhere restarts the fill from word 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      clr_addr <= '0;
    end else begin
      state    <= state_nxt;
      clr_addr <= clr_nxt;
    end
  end

  // Next state: advance the clear one word per enabled cycle, then settle in READY for good.
  always_comb begin
    state_nxt = state;
    clr_nxt   = clr_addr;
    if (state == ST_CLEAR && en) begin
      if (clr_addr == CLR_END) state_nxt = ST_READY;
      else                     clr_nxt   = clr_addr + 1'b1;
    end
  end

  // Request decode; a simultaneous read and write on one port is treated as a write only.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      in_rng[p]  = ({1'b0, addr_i[p]} < DEPTH_A);
      wr_acc[p]  = ready & en & ~reset & cs_i[p] & wr_i[p];
      rd_acc[p]  = ready & en & ~reset & cs_i[p] & rd_i[p] & ~wr_i[p];
      rd_word[p] = in_rng[p] ? mem[addr_i[p][IW-1:0]] : '0;
    end
  end

  // Array writes: port 2 lanes first so port 1 overrides the lanes both ports enable.
  always_ff @(posedge clk) begin
    if (clr_wr) mem[clr_addr[IW-1:0]] <= '0;
    for (int p = 1; p >= 0; p--) begin
      if (wr_acc[p] && in_rng[p]) begin
        for (int b = 0; b < NB; b++) begin
          if (be_i[p][b]) mem[addr_i[p][IW-1:0]][8*b +: 8] <= wd_i[p][8*b +: 8];
        end
      end
    end
  end

  // Read pipeline: frozen while disabled, readdata only moves when a valid word arrives.
  always_ff @(posedge clk) begin
    if (reset) begin
      p1_vld  <= '0;
      out_vld <= '0;
      for (int p = 0; p < 2; p++) begin
        p1_dat[p]  <= '0;
        out_dat[p] <= '0;
      end
    end else if (en) begin
      for (int p = 0; p < 2; p++) begin
        p1_vld[p] <= rd_acc[p];
        if (rd_acc[p]) p1_dat[p] <= rd_word[p];
        if (READ_LATENCY == 2) begin
          out_vld[p] <= p1_vld[p];
          if (p1_vld[p]) out_dat[p] <= p1_dat[p];
        end else begin
          out_vld[p] <= rd_acc[p];
          if (rd_acc[p]) out_dat[p] <= rd_word[p];
        end
      end
    end
  end

  assign s1_readdata      = out_dat[0];
  assign s2_readdata      = out_dat[1];
  assign s1_readdatavalid = out_vld[0] & en;
  assign s2_readdatavalid = out_vld[1] & en;
  assign s1_waitrequest   = ~ready;
  assign s2_waitrequest   = ~ready;
  assign clear_done       = ready;

endmodule

// File: tb/tb_embedded_system_onchip_memory_dp.sv
// Bench for the dual-port RAM: one 1-cycle and one 2-cycle instance driven by identical stimulus.
// Expected read data and arrival time are queued at drive time and retired as readdatavalid pulses appear.
module tb_embedded_system_onchip_memory_dp;

  typedef struct packed {
    logic [31:0] e;
    logic [31:0] d;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, reset_req, clken;
  logic        cs [2];
  logic        rd [2];
  logic        wr [2];
  logic [4:0]  addr [2];
  logic [3:0]  be [2];
  logic [31:0] wd [2];

  // Index k: 0 = lat1 s1, 1 = lat1 s2, 2 = lat2 s1, 3 = lat2 s2.
  logic [31:0] o_rd   [4];
  logic        o_vld  [4];
  logic        o_wait [4];
  logic        o_done [2];

  logic [31:0] ref_mem [16];
  exp_t        sbq [4][$];
  logic [31:0] ecnt = 0;
  int          vectors = 0;
  int          errs = 0;

  always #5 clk = ~clk;

  embedded_system_onchip_memory_dp #(
    .DATA_WIDTH(32), .DEPTH(16), .ADDR_WIDTH(5), .READ_LATENCY(1), .CLEAR_ON_RESET(1)
  ) d1 (
    .clk(clk), .reset(reset), .reset_req(reset_req), .clken(clken),
    .s1_address(addr[0]), .s1_chipselect(cs[0]), .s1_read(rd[0]), .s1_write(wr[0]),
    .s1_byteenable(be[0]), .s1_writedata(wd[0]), .s1_readdata(o_rd[0]),
    .s1_readdatavalid(o_vld[0]), .s1_waitrequest(o_wait[0]),
    .s2_address(addr[1]), .s2_chipselect(cs[1]), .s2_read(rd[1]), .s2_write(wr[1]),
    .s2_byteenable(be[1]), .s2_writedata(wd[1]), .s2_readdata(o_rd[1]),
    .s2_readdatavalid(o_vld[1]), .s2_waitrequest(o_wait[1]),
    .clear_done(o_done[0])
  );

  embedded_system_onchip_memory_dp #(
    .DATA_WIDTH(32), .DEPTH(16), .ADDR_WIDTH(5), .READ_LATENCY(2), .CLEAR_ON_RESET(1)
  ) d2 (
    .clk(clk), .reset(reset), .reset_req(reset_req), .clken(clken),
    .s1_address(addr[0]), .s1_chipselect(cs[0]), .s1_read(rd[0]), .s1_write(wr[0]),
    .s1_byteenable(be[0]), .s1_writedata(wd[0]), .s1_readdata(o_rd[2]),
    .s1_readdatavalid(o_vld[2]), .s1_waitrequest(o_wait[2]),
    .s2_address(addr[1]), .s2_chipselect(cs[1]), .s2_read(rd[1]), .s2_write(wr[1]),
    .s2_byteenable(be[1]), .s2_writedata(wd[1]), .s2_readdata(o_rd[3]),
    .s2_readdatavalid(o_vld[3]), .s2_waitrequest(o_wait[3]),
    .clear_done(o_done[1])
  );

  // Enabled-cycle counter: read latency is measured in these, so stalls stretch it naturally.
  always @(posedge clk) begin
    if (clken && !reset_req) ecnt <= ecnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic mon(input int k, input logic v, input logic [31:0] d);
    exp_t h;
    if (v) begin
      chk($sformatf("vld_expected_%0d", k), 32'(sbq[k].size() != 0), 32'd1);
      if (sbq[k].size() != 0) begin
        h = sbq[k].pop_front();
        chk($sformatf("rd_dat_%0d", k), d, h.d);
        chk($sformatf("rd_lat_%0d", k), ecnt, h.e);
        chk($sformatf("vld_while_en_%0d", k), 32'(clken && !reset_req), 32'd1);
      end
    end else if (sbq[k].size() != 0 && sbq[k][0].e < ecnt) begin
      h = sbq[k].pop_front();
      chk($sformatf("vld_missing_%0d", k), 32'(v), 32'd1);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) mon(k, o_vld[k], o_rd[k]);
  end

  task automatic op(input int p, input logic r, input logic w, input logic [4:0] a,
                    input logic [3:0] b, input logic [31:0] d);
    cs[p] = 1'b1; rd[p] = r; wr[p] = w; addr[p] = a; be[p] = b; wd[p] = d;
  endtask

  // Model the edge about to happen (reads see pre-write contents), then advance one cycle.
  task automatic tick();
    logic en_m;
    exp_t x;
    en_m = clken && !reset_req;
    for (int p = 0; p < 2; p++) begin
      if (en_m && cs[p] && rd[p] && !wr[p]) begin
        x.d = (addr[p] < 5'd16) ? ref_mem[addr[p][3:0]] : 32'h0;
        x.e = ecnt + 1;
        sbq[p].push_back(x);
        x.e = ecnt + 2;
        sbq[p + 2].push_back(x);
      end
    end
    for (int p = 1; p >= 0; p--) begin
      if (en_m && cs[p] && wr[p] && addr[p] < 5'd16) begin
        for (int b = 0; b < 4; b++) begin
          if (be[p][b]) ref_mem[addr[p][3:0]][8*b +: 8] = wd[p][8*b +: 8];
        end
      end
    end
    @(posedge clk);
    #1;
    for (int p = 0; p < 2; p++) begin
      cs[p] = 1'b0; rd[p] = 1'b0; wr[p] = 1'b0;
    end
  endtask

  initial begin
    int c1, c2;
    reset = 1'b1; reset_req = 1'b0; clken = 1'b1;
    for (int p = 0; p < 2; p++) begin
      cs[p] = 1'b0; rd[p] = 1'b0; wr[p] = 1'b0; addr[p] = '0; be[p] = '0; wd[p] = '0;
    end
    for (int i = 0; i < 16; i++) ref_mem[i] = 32'h0;

    repeat (3) tick();
    chk("rst_readdata", o_rd[0], 32'h0);
    chk("rst_readdata_lat2", o_rd[3], 32'h0);
    chk("rst_waitrequest", 32'(o_wait[0]), 32'd1);

    // Release, then pull reset again part-way through the fill.
    reset = 1'b0;
    @(negedge clk);
    chk("clear_done_low", 32'(o_done[0]), 32'd0);
    repeat (8) tick();
    chk("clear_still_busy", 32'(o_wait[1]), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;

    c1 = 0; c2 = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (o_wait[0]) c1++;
      if (o_wait[2]) c2++;
      if (!o_wait[0] && !o_wait[2]) break;
    end
    chk("wait_cycles_lat1", c1, 32'd17);
    chk("wait_cycles_lat2", c2, 32'd17);
    chk("clear_done_high", 32'(o_done[0] && o_done[1]), 32'd1);
    chk("s2_wait_low", 32'(o_wait[1] || o_wait[3]), 32'd0);

    // Every word reads back zero, both ports back to back.
    for (int a = 0; a < 16; a++) begin
      op(0, 1'b1, 1'b0, 5'(a), 4'h0, 32'h0);
      op(1, 1'b1, 1'b0, 5'(15 - a), 4'h0, 32'h0);
      tick();
    end

    // Byte-lane merge.
    op(0, 1'b0, 1'b1, 5'd5, 4'hF, 32'hDEADBEEF); tick();
    op(0, 1'b0, 1'b1, 5'd5, 4'b0010, 32'h0000AA00); tick();
    op(1, 1'b1, 1'b0, 5'd5, 4'h0, 32'h0); tick();
    op(1, 1'b0, 1'b1, 5'd4, 4'h0, 32'hFFFFFFFF); tick();
    repeat (2) tick();
    chk("be_merge_lat1", o_rd[1], 32'hDEADAAEF);
    chk("be_merge_lat2", o_rd[3], 32'hDEADAAEF);

    // Back-to-back reads of distinct words.
    op(0, 1'b0, 1'b1, 5'd1, 4'hF, 32'hA1A1A1A1);
    op(1, 1'b0, 1'b1, 5'd2, 4'hF, 32'hA2A2A2A2); tick();
    op(0, 1'b0, 1'b1, 5'd3, 4'hF, 32'hA3A3A3A3); tick();
    for (int a = 1; a <= 3; a++) begin
      op(0, 1'b1, 1'b0, 5'(a), 4'h0, 32'h0);
      tick();
    end

    // Same-edge write collision.
    op(0, 1'b0, 1'b1, 5'd7, 4'hF, 32'h11111111);
    op(1, 1'b0, 1'b1, 5'd7, 4'hF, 32'h22222222); tick();
    op(1, 1'b1, 1'b0, 5'd7, 4'h0, 32'h0); tick();
    op(0, 1'b0, 1'b1, 5'd7, 4'b0001, 32'h11111111);
    op(1, 1'b0, 1'b1, 5'd7, 4'hF, 32'h22222222); tick();
    op(0, 1'b1, 1'b0, 5'd7, 4'h0, 32'h0); tick();
    repeat (2) tick();
    chk("collide_full_s1", o_rd[1], 32'h11111111);
    chk("collide_lane_mix", o_rd[0], 32'h22222211);

    // Read-during-write returns old data.
    op(0, 1'b0, 1'b1, 5'd9, 4'hF, 32'h3); tick();
    op(0, 1'b1, 1'b0, 5'd9, 4'h0, 32'h0);
    op(1, 1'b0, 1'b1, 5'd9, 4'hF, 32'h5); tick();
    op(0, 1'b1, 1'b0, 5'd9, 4'h0, 32'h0); tick();
    repeat (2) tick();
    chk("rdw_new_value", o_rd[2], 32'h5);

    // Read+write on one port: write only, no valid.
    op(0, 1'b1, 1'b1, 5'd3, 4'hF, 32'h33333333); tick();
    op(1, 1'b1, 1'b0, 5'd3, 4'h0, 32'h0); tick();

    // Out of range: write dropped (no alias onto word 0), read gives zero.
    op(0, 1'b0, 1'b1, 5'd0, 4'hF, 32'h0A0A0A0A); tick();
    op(0, 1'b0, 1'b1, 5'd16, 4'hF, 32'hBADBADBA); tick();
    op(1, 1'b1, 1'b0, 5'd16, 4'h0, 32'h0);
    op(0, 1'b1, 1'b0, 5'd0, 4'h0, 32'h0); tick();
    repeat (3) tick();

    // Clock-enable stall mid-read; write attempted during the stall is dropped.
    op(0, 1'b1, 1'b0, 5'd5, 4'h0, 32'h0); tick();
    clken = 1'b0;
    op(1, 1'b0, 1'b1, 5'd5, 4'hF, 32'hFFFFFFFF); tick();
    repeat (2) tick();
    clken = 1'b1;
    @(negedge clk);
    chk("stall_vld_lat1", 32'(o_vld[0]), 32'd1);
    chk("stall_vld_lat2_pending", 32'(o_vld[2]), 32'd0);
    repeat (2) tick();

    // reset_req suspends writes the same way.
    reset_req = 1'b1;
    op(0, 1'b0, 1'b1, 5'd6, 4'hF, 32'h12345678); tick();
    reset_req = 1'b0;
    op(0, 1'b1, 1'b0, 5'd6, 4'h0, 32'h0);
    op(1, 1'b1, 1'b0, 5'd5, 4'h0, 32'h0); tick();

    repeat (6) tick();
    for (int k = 0; k < 4; k++) chk($sformatf("sb_drained_%0d", k), sbq[k].size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
